// File: rtl/vote_pkg.sv
// Shared types and constants for the vote arbiter and the tally datapath.
package vote_pkg;

    // Poll session life cycle.
    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StOpen,
        StDrain,
        StClosed
    } vote_state_t;

    // Candidate code meaning "no vote".
    localparam int unsigned CAND_NONE = 0;

    // Defaults shared with voting_machine.
    localparam int unsigned CAND_W_DEFAULT   = 3;
    localparam int unsigned NUM_CAND_DEFAULT = 3;

    // Width of a booth index; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after ptr_i.
module rr_arbiter
    import vote_pkg::*;
#(
    parameter int unsigned NUM_BOOTHS = 4,
    parameter int unsigned PTR_W      = ptr_width(NUM_BOOTHS)
) (
    input  logic [NUM_BOOTHS-1:0] req_i,
    input  logic [NUM_BOOTHS-1:0] mask_i,
    input  logic [PTR_W-1:0]      ptr_i,
    output logic [NUM_BOOTHS-1:0] gnt_o,
    output logic                  valid_o
);

    localparam logic [PTR_W:0] NumB = (PTR_W + 1)'(NUM_BOOTHS);

    logic [NUM_BOOTHS-1:0] eligible;
    logic [PTR_W-1:0]      idx;

    assign eligible = req_i & ~mask_i;

    // ptr_i + off modulo NUM_BOOTHS; both operands are below NUM_BOOTHS.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        logic [PTR_W:0] s;
        s = {1'b0, base} + (PTR_W + 1)'(off);
        if (s >= NumB) begin
            s = s - NumB;
        end
        return s[PTR_W-1:0];
    endfunction

    // Scan from the pointer in modulo order and grant the first eligible booth.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_BOOTHS; i++) begin
            idx = wrap_idx(ptr_i, i);
            if (!valid_o && eligible[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vote_arbiter.sv
// Poll session controller sharing one tally datapath between several booths.
module vote_arbiter
    import vote_pkg::*;
#(
    parameter int unsigned NUM_BOOTHS = 4,
    parameter int unsigned CAND_W     = CAND_W_DEFAULT,
    parameter int unsigned NUM_CAND   = NUM_CAND_DEFAULT,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         open_poll,
    input  logic                         close_poll,
    input  logic [NUM_BOOTHS-1:0]        booth_req,
    input  logic [NUM_BOOTHS*CAND_W-1:0] booth_cand,
    output logic [NUM_BOOTHS-1:0]        booth_ack,
    output logic                         reject,
    output logic                         tally_en,
    output logic [CAND_W-1:0]            tally_cand,
    output logic                         tally_clr,
    output logic                         poll_open,
    output logic                         results_valid,
    output logic [CNT_W-1:0]             votes_cast
);

    localparam int unsigned PtrW = ptr_width(NUM_BOOTHS);

    vote_state_t state_q, state_d;

    logic [PtrW-1:0]              ptr_q, ptr_d;
    logic [NUM_BOOTHS-1:0]        req_q;
    logic [NUM_BOOTHS*CAND_W-1:0] cand_q;
    logic [NUM_BOOTHS-1:0]        ack_q, ack_d;
    logic                         reject_q, reject_d;
    logic                         tally_en_q, tally_en_d;
    logic [CAND_W-1:0]            tally_cand_q, tally_cand_d;
    logic                         tally_clr_q, tally_clr_d;
    logic                         poll_open_q, poll_open_d;
    logic                         results_valid_q, results_valid_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    logic [NUM_BOOTHS-1:0] gnt;
    logic                  gnt_valid;
    logic                  grant_en;
    logic [PtrW-1:0]       gnt_idx;
    logic [CAND_W-1:0]     gnt_cand;
    logic                  cand_ok;
    logic                  count_vote;

    // The booth acked this cycle is masked so it cannot win twice in a row.
    rr_arbiter #(
        .NUM_BOOTHS (NUM_BOOTHS),
        .PTR_W      (PtrW)
    ) u_rr_arbiter (
        .req_i   (req_q),
        .mask_i  (ack_q),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .valid_o (gnt_valid)
    );

    // Grants wait for the registered poll_open so the first ack trails it by a cycle.
    assign grant_en = (state_q == StOpen) && poll_open_q && gnt_valid;

    // Decode the one-hot grant into an index and the winning candidate code.
    always_comb begin
        gnt_idx  = '0;
        gnt_cand = '0;
        for (int unsigned i = 0; i < NUM_BOOTHS; i++) begin
            if (gnt[i]) begin
                gnt_idx  = PtrW'(i);
                gnt_cand = cand_q[i*CAND_W +: CAND_W];
            end
        end
    end

    assign cand_ok    = (32'(gnt_cand) != CAND_NONE) && (32'(gnt_cand) <= NUM_CAND);
    assign count_vote = grant_en && cand_ok && !(&cnt_q);

    // Session life cycle; a close in OPEN takes priority over a reopen.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (open_poll) state_d = StClear;
            StClear:  state_d = StOpen;
            StOpen:   if (close_poll) state_d = StDrain;
            StDrain:  state_d = StClosed;
            StClosed: if (open_poll) state_d = StClear;
            default:  state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, pointer and vote counter.
    always_comb begin
        ack_d           = grant_en ? gnt : '0;
        reject_d        = grant_en && !count_vote;
        tally_en_d      = count_vote;
        tally_cand_d    = count_vote ? gnt_cand : '0;
        tally_clr_d     = (state_q == StClear);
        poll_open_d     = (state_q == StOpen);
        results_valid_d = (state_q == StClosed);
        cnt_d           = cnt_q;
        ptr_d           = ptr_q;
        if (state_q == StClear) begin
            cnt_d = '0;
            ptr_d = '0;
        end else begin
            if (count_vote) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (grant_en) begin
                ptr_d = (gnt_idx == PtrW'(NUM_BOOTHS - 1)) ? '0 : gnt_idx + PtrW'(1);
            end
        end
    end

    // State and output registers. A request bit that was just acked is dropped on
    // capture because the booth only releases it one cycle after the ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            ptr_q           <= '0;
            req_q           <= '0;
            cand_q          <= '0;
            ack_q           <= '0;
            reject_q        <= 1'b0;
            tally_en_q      <= 1'b0;
            tally_cand_q    <= '0;
            tally_clr_q     <= 1'b0;
            poll_open_q     <= 1'b0;
            results_valid_q <= 1'b0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            req_q           <= booth_req & ~ack_q;
            cand_q          <= booth_cand;
            ack_q           <= ack_d;
            reject_q        <= reject_d;
            tally_en_q      <= tally_en_d;
            tally_cand_q    <= tally_cand_d;
            tally_clr_q     <= tally_clr_d;
            poll_open_q     <= poll_open_d;
            results_valid_q <= results_valid_d;
            cnt_q           <= cnt_d;
        end
    end

    assign booth_ack     = ack_q;
    assign reject        = reject_q;
    assign tally_en      = tally_en_q;
    assign tally_cand    = tally_cand_q;
    assign tally_clr     = tally_clr_q;
    assign poll_open     = poll_open_q;
    assign results_valid = results_valid_q;
    assign votes_cast    = cnt_q;

endmodule

// File: tb/tb_vote_arbiter.sv
// Scoreboard bench for vote_arbiter; a second instance with a 2-bit counter
// shares the stimulus to exercise saturation.
module tb_vote_arbiter;

    localparam int NB = 4;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           open_poll = 1'b0;
    logic           close_poll = 1'b0;
    logic [NB-1:0]  booth_req = '0;
    logic [NB*CW-1:0] booth_cand = '0;

    logic [NB-1:0]  booth_ack, booth_ack_s;
    logic           reject, reject_s;
    logic           tally_en, tally_en_s;
    logic [CW-1:0]  tally_cand, tally_cand_s;
    logic           tally_clr, tally_clr_s;
    logic           poll_open, poll_open_s;
    logic           results_valid, results_valid_s;
    logic [7:0]     votes_cast;
    logic [1:0]     votes_cast_s;

    vote_arbiter #(.NUM_BOOTHS(NB), .CAND_W(CW), .NUM_CAND(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .open_poll(open_poll), .close_poll(close_poll),
        .booth_req(booth_req), .booth_cand(booth_cand), .booth_ack(booth_ack),
        .reject(reject), .tally_en(tally_en), .tally_cand(tally_cand),
        .tally_clr(tally_clr), .poll_open(poll_open), .results_valid(results_valid),
        .votes_cast(votes_cast)
    );

    vote_arbiter #(.NUM_BOOTHS(NB), .CAND_W(CW), .NUM_CAND(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .open_poll(open_poll), .close_poll(close_poll),
        .booth_req(booth_req), .booth_cand(booth_cand), .booth_ack(booth_ack_s),
        .reject(reject_s), .tally_en(tally_en_s), .tally_cand(tally_cand_s),
        .tally_clr(tally_clr_s), .poll_open(poll_open_s),
        .results_valid(results_valid_s), .votes_cast(votes_cast_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int booth;
        int cand;
        bit rej;
        bit rej_s;
    } exp_t;

    exp_t    sb[$];
    int      ack_cycles[$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      exp_cnt = 0;
    int      exp_cnt_s = 0;
    logic [NB-1:0] drop_pend = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outcome of the next ack, from a counter model per instance.
    task automatic expect_vote(input int booth, input int cand);
        exp_t e;
        bit   ok;
        ok      = (cand >= 1) && (cand <= 3);
        e.booth = booth;
        e.cand  = cand;
        e.rej   = !(ok && exp_cnt < 255);
        e.rej_s = !(ok && exp_cnt_s < 3);
        if (!e.rej) exp_cnt++;
        if (!e.rej_s) exp_cnt_s++;
        sb.push_back(e);
    endtask

    task automatic drive_req(input int b, input int code);
        booth_req[b] = 1'b1;
        booth_cand[b*CW +: CW] = CW'(code);
    endtask

    // One cycle: advance to the falling edge, score any ack, then act as the booths.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (booth_ack != '0 || booth_ack_s != '0) begin
            check_eq("sat_ack_match", 32'(booth_ack_s), 32'(booth_ack));
            if (sb.size() == 0) begin
                check_eq("unexpected_ack", 32'(booth_ack), 32'd0);
            end else begin
                e = sb.pop_front();
                ack_cycles.push_back(cyc);
                check_eq("ack_onehot", 32'(booth_ack), 32'd1 << e.booth);
                check_eq("reject", 32'(reject), 32'(e.rej));
                check_eq("tally_en", 32'(tally_en), 32'(!e.rej));
                if (!e.rej) check_eq("tally_cand", 32'(tally_cand), 32'(e.cand));
                check_eq("sat_reject", 32'(reject_s), 32'(e.rej_s));
                check_eq("sat_tally_en", 32'(tally_en_s), 32'(!e.rej_s));
                if (!e.rej_s) check_eq("sat_tally_cand", 32'(tally_cand_s), 32'(e.cand));
            end
        end
        if (tally_en || tally_clr) begin
            check_eq("en_clr_exclusive", 32'(tally_en && tally_clr), 32'd0);
        end
        for (int i = 0; i < NB; i++) begin
            if (drop_pend[i]) begin
                booth_req[i] = 1'b0;
                drop_pend[i] = 1'b0;
            end
            if (booth_ack[i]) drop_pend[i] = 1'b1;
        end
    endtask

    task automatic drain(input int max_cycles);
        for (int c = 0; c < max_cycles && sb.size() != 0; c++) tick();
        if (sb.size() != 0) begin
            check_eq("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        tick();
        tick();
    endtask

    task automatic open_session();
        exp_cnt   = 0;
        exp_cnt_s = 0;
        open_poll = 1'b1;
        tick();
        open_poll = 1'b0;
        check_eq("clr_before", 32'(tally_clr), 32'd0);
        tick();
        check_eq("clr_pulse", 32'(tally_clr), 32'd1);
        check_eq("open_during_clr", 32'(poll_open), 32'd0);
        tick();
        check_eq("clr_after", 32'(tally_clr), 32'd0);
        check_eq("poll_open", 32'(poll_open), 32'd1);
        check_eq("votes_zero", 32'(votes_cast), 32'd0);
        check_eq("sat_votes_zero", 32'(votes_cast_s), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        tick();
        tick();
        check_eq("rst_ack", 32'(booth_ack), 32'd0);
        check_eq("rst_reject", 32'(reject), 32'd0);
        check_eq("rst_tally_en", 32'(tally_en), 32'd0);
        check_eq("rst_tally_cand", 32'(tally_cand), 32'd0);
        check_eq("rst_tally_clr", 32'(tally_clr), 32'd0);
        check_eq("rst_poll_open", 32'(poll_open), 32'd0);
        check_eq("rst_results", 32'(results_valid), 32'd0);
        check_eq("rst_votes", 32'(votes_cast), 32'd0);
        check_eq("rst_sat_flags", 32'({tally_clr_s, poll_open_s, results_valid_s}), 32'd0);
        rst = 1'b1;
        tick();

        // All four booths vote for candidate 1 at once.
        open_session();
        ack_cycles.delete();
        for (int b = 0; b < NB; b++) begin
            drive_req(b, 1);
            expect_vote(b, 1);
        end
        drain(20);
        check_eq("ack_count", 32'(ack_cycles.size()), 32'd4);
        if (ack_cycles.size() == 4) begin
            check_eq("ack_back_to_back", 32'(ack_cycles[3] - ack_cycles[0]), 32'd3);
        end
        check_eq("votes_after_4", 32'(votes_cast), 32'(exp_cnt));
        check_eq("sat_votes_after_4", 32'(votes_cast_s), 32'(exp_cnt_s));

        // Invalid codes: no vote, and above the candidate range.
        drive_req(2, 0);
        expect_vote(2, 0);
        drain(20);
        check_eq("votes_after_code0", 32'(votes_cast), 32'(exp_cnt));
        drive_req(2, 5);
        expect_vote(2, 5);
        drain(20);
        check_eq("votes_after_code5", 32'(votes_cast), 32'(exp_cnt));

        // Close on the same edge as a grant.
        drive_req(1, 2);
        expect_vote(1, 2);
        tick();
        close_poll = 1'b1;
        tick();
        close_poll = 1'b0;
        check_eq("open_at_close", 32'(poll_open), 32'd1);
        drive_req(0, 3);
        tick();
        check_eq("open_falls", 32'(poll_open), 32'd0);
        check_eq("results_not_yet", 32'(results_valid), 32'd0);
        tick();
        check_eq("results_valid", 32'(results_valid), 32'd1);
        check_eq("votes_at_close", 32'(votes_cast), 32'(exp_cnt));
        repeat (6) tick();
        check_eq("votes_held_closed", 32'(votes_cast), 32'(exp_cnt));
        check_eq("sb_empty_closed", 32'(sb.size()), 32'd0);

        // Reopen from CLOSED: the pending booth 0 is served in the new session.
        open_session();
        expect_vote(0, 3);
        drain(20);
        check_eq("votes_reopen", 32'(votes_cast), 32'(exp_cnt));

        // Asynchronous reset mid-session with requests pending.
        drive_req(0, 1);
        drive_req(1, 2);
        drive_req(2, 3);
        drive_req(3, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        drop_pend = '0;
        check_eq("arst_poll_open", 32'(poll_open), 32'd0);
        check_eq("arst_votes", 32'(votes_cast), 32'd0);
        check_eq("arst_ack", 32'(booth_ack), 32'd0);
        check_eq("arst_tally_en", 32'(tally_en), 32'd0);
        check_eq("arst_sat_votes", 32'(votes_cast_s), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        repeat (4) tick();
        check_eq("idle_after_arst", 32'(poll_open), 32'd0);
        open_session();
        ack_cycles.delete();
        expect_vote(0, 1);
        expect_vote(1, 2);
        expect_vote(2, 3);
        expect_vote(3, 0);
        drain(20);
        check_eq("restart_acks", 32'(ack_cycles.size()), 32'd4);
        check_eq("votes_restart", 32'(votes_cast), 32'(exp_cnt));
        check_eq("sat_votes_restart", 32'(votes_cast_s), 32'(exp_cnt_s));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vote_arbiter.md
# vote_arbiter

Session controller and round-robin arbiter that shares one `voting_machine` tally datapath between `NUM_BOOTHS` voting booths. It owns the poll life cycle: clear, open, drain and closed. Each booth presents a candidate code over a req/ack handshake, and the block issues at most one tally strobe per cycle. It sits between the booth input logic and the tally/winner datapath, and drives that datapath's increment and clear controls.

## Interface
Parameters:
- `NUM_BOOTHS`, 4: number of requesting booths, 2..8.
- `CAND_W`, 3: candidate code width. Code 0 means no vote.
- `NUM_CAND`, 3: valid candidate codes are 1..`NUM_CAND`.
- `CNT_W`, 8: width of the total-votes counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `open_poll`  in  1: single-cycle pulse; starts a new session.
- `close_poll`  in  1: single-cycle pulse; ends the session.
- `booth_req`  in  `NUM_BOOTHS`: per-booth vote request, level.
- `booth_cand`  in  `NUM_BOOTHS*CAND_W`: booth i's code is in slice [i*CAND_W +: CAND_W].
- `booth_ack`  out  `NUM_BOOTHS`: one-hot, single-cycle acknowledge.
- `reject`  out  1: pulses together with `booth_ack` when the acked vote was not counted.
- `tally_en`  out  1: increment strobe to the tally datapath.
- `tally_cand`  out  `CAND_W`: candidate to increment. Valid only while `tally_en` is high.
- `tally_clr`  out  1: clears the tally datapath counters.
- `poll_open`  out  1: high in OPEN.
- `results_valid`  out  1: high in CLOSED.
- `votes_cast`  out  `CNT_W`: number of counted votes this session.

## Operation
- FSM states are IDLE, CLEAR, OPEN, DRAIN and CLOSED.
- IDLE goes to CLEAR on `open_poll`. CLOSED also goes to CLEAR on `open_poll`.
- CLEAR lasts one cycle and asserts `tally_clr`. It zeroes `votes_cast` and resets the RR pointer to 0, then moves to OPEN.
- OPEN goes to DRAIN on `close_poll`. If `open_poll` and `close_poll` arrive together in OPEN, the close wins.
- DRAIN lasts one cycle and grants nothing, then moves to CLOSED.
- In IDLE, CLEAR, DRAIN and CLOSED, `close_poll` is ignored, and `booth_req` stays pending with no ack.
- Arbitration:
  - Arbitration runs only in OPEN.
  - The winner is the first requesting booth at or after the RR pointer, in modulo order.
  - After a grant, the pointer moves to winner+1, wrapping at `NUM_BOOTHS`.
  - A booth whose `booth_ack` is high this cycle is masked out, so a booth is never granted on back-to-back cycles.
- Handshake rules:
  - A booth holds `booth_req` and its code stable until it sees `booth_ack`.
  - The booth deasserts `booth_req` on the cycle after `booth_ack`.
  - Withdrawing a request before the ack is illegal.
- A granted code is counted only if it is in 1..`NUM_CAND` and `votes_cast` < 2^`CNT_W`-1. In that case the block asserts `tally_en`, drives `tally_cand`, and increments `votes_cast`.
- Otherwise the vote is acked with `reject`=1 and `tally_en`=0. This covers code 0, codes above `NUM_CAND`, and the saturated counter.
- `votes_cast` saturates and never wraps. It holds its value through DRAIN and CLOSED until the next CLEAR.

## Timing
- Reset state:
  - State is IDLE and the RR pointer is 0.
  - Every output is 0: `booth_ack`, `reject`, `tally_en`, `tally_cand`, `tally_clr`, `poll_open`, `results_valid`, `votes_cast`.
- Reset is fully asynchronous. A reset mid-session drops any in-flight grant and no ack is issued for it. The tally datapath is reset by the same `rst`.
- All outputs are registered.
- Request latency: a `booth_req` sampled high at edge t gives `booth_ack`, `reject` and `tally_en` high for the cycle after edge t+1. Sustained throughput is one vote per cycle.
- `open_poll` at edge t gives `tally_clr` after edge t+1. `poll_open` rises after edge t+2. The first possible ack comes after edge t+3.
- `close_poll` in OPEN at edge t: a grant made at edge t still acks and tallies in the following cycle. `poll_open` falls after edge t+1. `results_valid` rises after edge t+2.
- `tally_en` and `tally_clr` are never high in the same cycle.

## Structure
- Package `vote_pkg` holds:
  - the state enum `vote_state_t`;
  - `CAND_NONE` = 0;
  - the default `CAND_W` and `NUM_CAND` constants, shared with `voting_machine`.
- Sub-module `rr_arbiter`, parameterised by `NUM_BOOTHS`:
  - inputs: request vector, mask, pointer;
  - outputs: one-hot grant and a valid flag;
  - purely combinational.
- Top level holds the FSM, pointer, output registers and saturating counter.

## Test plan
- Reset then `open_poll`: `tally_clr` is high for exactly one cycle, then `poll_open`=1 and `votes_cast`=0.
- Booths 0..3 all request code 1 at once, held stable: acks arrive in order 0,1,2,3 on consecutive cycles, 4 `tally_en` pulses occur, and `votes_cast`=4.
- Booth 2 requests code 0, and separately code 5 with `NUM_CAND`=3: each is acked with `reject`=1 and `tally_en`=0, and `votes_cast` is unchanged.
- With `CNT_W`=2: the first 3 valid votes are counted, the 4th is rejected, and `votes_cast` stays at 3.
- `close_poll` on the same cycle as a grant: that vote is tallied, later requests get no ack, and `results_valid`=1 two cycles after the close.
- Assert `rst` low mid-OPEN with requests pending: all outputs drop to 0 immediately and the FSM returns to IDLE. A following `open_poll` restarts from booth 0.
